// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 matrix keypad scanner with debounce and one-shot key code output
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] invalue,
  output logic       key_valid
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [3:0]    NO_CMD   = 4'd13;

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_EMIT, ST_RELEASE} state_t;

  state_t          state, state_d;
  logic [2:0]      col_meta, col_sync;
  logic [DW-1:0]   div;
  logic [1:0]      row_idx, row_d;
  logic [1:0]      lat_col, lat_d;
  logic [CW-1:0]   stable_cnt, stable_d;
  logic [CW-1:0]   rel_cnt, rel_d;
  logic            tick;
  logic            one_low;
  logic [1:0]      col_idx;
  logic            latched_alone;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    if (r == 2'd3) begin
      case (c)
        2'd0:    return 4'd11;
        2'd1:    return 4'd0;
        default: return 4'd10;
      endcase
    end
    return ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
  endfunction

  assign tick  = (div == DIV_LAST);
  assign row_n = ~(4'b0001 << row_idx);

  always_comb begin
    one_low = 1'b1;
    col_idx = 2'd0;
    case (col_sync)
      3'b110:  col_idx = 2'd0;
      3'b101:  col_idx = 2'd1;
      3'b011:  col_idx = 2'd2;
      default: one_low = 1'b0;
    endcase
  end

  assign latched_alone = (col_sync == ~(3'b001 << lat_col));

  always_comb begin
    state_d  = state;
    row_d    = row_idx;
    lat_d    = lat_col;
    stable_d = stable_cnt;
    rel_d    = rel_cnt;
    case (state)
      ST_SCAN: if (tick) begin
        // Multi-column patterns are ghosting and are treated like no press.
        if (one_low) begin
          lat_d    = col_idx;
          stable_d = '0;
          state_d  = ST_DEBOUNCE;
        end else begin
          row_d = row_idx + 2'd1;
        end
      end
      ST_DEBOUNCE: if (tick) begin
        if (latched_alone) begin
          stable_d = stable_cnt + CW'(1);
          if (stable_cnt == CNT_LAST) state_d = ST_EMIT;
        end else begin
          stable_d = '0;
          row_d    = row_idx + 2'd1;
          state_d  = ST_SCAN;
        end
      end
      ST_EMIT: begin
        rel_d   = '0;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: if (tick) begin
        if (col_sync == 3'b111) begin
          rel_d = rel_cnt + CW'(1);
          if (rel_cnt == CNT_LAST) begin
            row_d   = row_idx + 2'd1;
            state_d = ST_SCAN;
          end
        end else begin
          rel_d = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta   <= 3'b111;
      col_sync   <= 3'b111;
      div        <= '0;
      state      <= ST_SCAN;
      row_idx    <= 2'd0;
      lat_col    <= 2'd0;
      stable_cnt <= '0;
      rel_cnt    <= '0;
      invalue    <= NO_CMD;
      key_valid  <= 1'b0;
    end else begin
      col_meta   <= col_n;
      col_sync   <= col_meta;
      div        <= tick ? '0 : div + DW'(1);
      state      <= state_d;
      row_idx    <= row_d;
      lat_col    <= lat_d;
      stable_cnt <= stable_d;
      rel_cnt    <= rel_d;
      // Outputs are registered so the code is present exactly while in EMIT.
      if (state_d == ST_EMIT) begin
        invalue   <= key_code(row_idx, lat_col);
        key_valid <= 1'b1;
      end else begin
        invalue   <= NO_CMD;
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a modelled key matrix
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [3:0] invalue;
  logic       key_valid;
  logic [11:0] pressed;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk(clk), .rst(rst), .col_n(col_n),
    .row_n(row_n), .invalue(invalue), .key_valid(key_valid)
  );

  // Key (r,c) is bit r*3+c; a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!row_n[r] && pressed[r*3+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key: got %0d expected none at %0t", invalue, $time);
      end else begin
        check("key_code", invalue, exp_q.pop_front());
      end
    end else begin
      check("idle_code", invalue, 13);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_row0_entry();
    int n = 0;
    while (row_n == 4'b1110 && n < 40) begin @(negedge clk); n++; end
    while (row_n != 4'b1110 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) check("row0_timeout", 0, 1);
  endtask

  task automatic press_release(input int idx, input logic [3:0] code);
    exp_q.push_back(code);
    pressed[idx] = 1'b1;
    cycles(40);
    pressed[idx] = 1'b0;
    cycles(20);
  endtask

  initial begin
    logic [3:0] er;
    logic       seen_row3;
    int         n;
    rst = 1'b0;
    pressed = '0;
    cycles(3);
    check("rst_row_n", row_n, 4'b1110);
    check("rst_invalue", invalue, 13);
    check("rst_key_valid", key_valid, 0);
    rst = 1'b1;

    // Idle scan: row index advances every 4 cycles from reset release.
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      er = ~(4'b0001 << ((k / 4) % 4));
      check("idle_row_n", row_n, er);
    end

    // Hold "6" (r1,c2), then release: row stays held until two all-high ticks.
    exp_q.push_back(4'd6);
    pressed[5] = 1'b1;
    cycles(40);
    check("held_row6", row_n, 4'b1101);
    pressed[5] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("release_hold_row", row_n, 4'b1101);
    end
    n = 0;
    while (row_n == 4'b1101 && n < 12) begin @(negedge clk); n++; end
    check("release_row_moves", int'(row_n != 4'b1101), 1);
    cycles(20);

    // Star then hash.
    press_release(9, 4'd11);
    press_release(11, 4'd10);

    // Bounce on "2": one tick low, one tick high (aborts), then stable low.
    wait_row0_entry();
    exp_q.push_back(4'd2);
    pressed[1] = 1'b1;
    cycles(4);
    pressed[1] = 1'b0;
    cycles(4);
    check("bounce_abort_row", row_n, 4'b1101);
    pressed[1] = 1'b1;
    cycles(40);
    pressed[1] = 1'b0;
    cycles(20);

    // Ghosting: two columns low on row 2, scanning must keep going.
    pressed[6] = 1'b1;
    pressed[7] = 1'b1;
    seen_row3 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (row_n == 4'b0111) seen_row3 = 1'b1;
    end
    check("ghost_scan_continues", seen_row3, 1);
    pressed = '0;
    cycles(10);

    // Second keys pressed while "5" is held are ignored.
    exp_q.push_back(4'd5);
    pressed[4] = 1'b1;
    cycles(40);
    pressed[3] = 1'b1;
    pressed[8] = 1'b1;
    cycles(40);
    pressed = '0;
    cycles(20);

    // Reset during DEBOUNCE with "1" held, then re-debounce; reset mid-emit.
    wait_row0_entry();
    pressed[0] = 1'b1;
    cycles(5);
    rst = 1'b0;
    #1;
    check("mid_deb_rst_row_n", row_n, 4'b1110);
    check("mid_deb_rst_invalue", invalue, 13);
    check("mid_deb_rst_key_valid", key_valid, 0);
    cycles(2);
    rst = 1'b1;
    exp_q.push_back(4'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!key_valid && n < 60);
    check("redebounce_emitted", key_valid, 1);
    #1;
    rst = 1'b0;
    #1;
    check("mid_emit_rst_invalue", invalue, 13);
    check("mid_emit_rst_key_valid", key_valid, 0);
    check("mid_emit_rst_row_n", row_n, 4'b1110);
    pressed = '0;
    cycles(3);
    rst = 1'b1;
    cycles(20);

    check("pending_keys", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
